// File: rtl/eros_obi_pkg.sv
// OBI initiator-side request and response bundles (32-bit address and data).
package eros_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/eros_pkg.sv
// Shared definitions for the reg-to-OBI bridge: FSM state encoding and the default error read data.
package eros_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RVALID,
    ST_RESP,
    ST_DRAIN
  } reg2obi_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;

endpackage

// File: rtl/reg_pkg.sv
// Register-interface request and response bundles (32-bit address and data).
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi_bridge.sv
// Reg-interface responder that performs each reg access as a single OBI initiator transaction,
// with misaligned-address rejection and a bounded wait for rvalid.
module reg_to_obi_bridge
  import reg_pkg::*;
  import eros_obi_pkg::*;
  import eros_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  reg_req_t       reg_req_i,
  output reg_rsp_t       reg_rsp_o,
  output obi_req_t       obi_req_o,
  input  obi_resp_t      obi_resp_i,
  output logic           busy_o,
  output reg2obi_state_e state_o
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

  // Handshakes: the reg side completes in the single cycle reg_rsp_o.ready is high (ready comes
  // only from state, never from reg valid); the OBI address phase completes when req && gnt at a
  // rising edge, and its data phase completes on the first rvalid afterwards.

  reg2obi_state_e   state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (reg_req_i.valid) begin
          if (reg_req_i.addr[1:0] == 2'b00) begin
            addr_d  = reg_req_i.addr;
            we_d    = reg_req_i.write;
            wdata_d = reg_req_i.wdata;
            wstrb_d = reg_req_i.wstrb;
            state_d = ST_REQ;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        if (obi_resp_i.gnt) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RVALID;
        end
      end
      ST_WAIT_RVALID: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving in the timeout cycle still counts as a normal completion.
        if (obi_resp_i.rvalid) begin
          rdata_d = we_q ? 32'h0 : obi_resp_i.rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          drain_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = drain_q ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        // No bound here: the late rvalid must be consumed before another OBI request may issue.
        if (obi_resp_i.rvalid) begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    obi_req_o = '0;
    if (state_q == ST_REQ) begin
      obi_req_o.req   = 1'b1;
      obi_req_o.we    = we_q;
      obi_req_o.be    = we_q ? wstrb_q : 4'hF;
      obi_req_o.addr  = addr_q;
      obi_req_o.wdata = wdata_q;
    end
  end

  assign reg_rsp_o.ready = (state_q == ST_RESP);
  assign reg_rsp_o.rdata = rdata_q;
  assign reg_rsp_o.error = err_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign state_o         = state_q;

endmodule
